// File: rtl/poll_sch_m_if.sv
// ---------------------------------------------------------------------------
// poll_sch_m_if
//
// Purpose : groups the poll scheduler's handshake and status signals so the
//           scheduler, the TX framer and the RX path connect through one
//           bundle. clk_sys and rst_n are not part of the bundle.
//
// Signals :
//   pluse_us   1-cycle tick every 1 us (timebase)
//   fire_sync  1-cycle pulse starting a poll cycle
//   tx_req     request to TX framer, held until tx_ack
//   tx_id      slave ID to transmit
//   tx_ack     1-cycle: framer accepted the request
//   tx_done    1-cycle: last bit shifted out
//   tx_ctrl    RS-485 driver enable (1 = master drives the line)
//   rx_valid   1-cycle: reply frame received
//   rx_id      source ID of the reply
//   rx_err     1-cycle: framing/CRC error on the received frame
//   busy       poll cycle in progress
//   cycle_done 1-cycle pulse when slave_ok is updated
//   slave_ok   per-slave reply bitmap of the last completed cycle
//   overrun    1-cycle: fire_sync arrived while busy
//   retry_cnt  retry counter (only when POLL_RETRY_EN is defined)
//
// Modports: master = scheduler side, slave = framer / RX / consumer side.
// Optional feature macro: POLL_RETRY_EN (adds retry_cnt).
// ---------------------------------------------------------------------------
interface poll_sch_m_if #(
  parameter int N_SLAVE = 8,
  parameter int ID_W    = 6
);
  logic               pluse_us;
  logic               fire_sync;
  logic               tx_req;
  logic [ID_W-1:0]    tx_id;
  logic               tx_ack;
  logic               tx_done;
  logic               tx_ctrl;
  logic               rx_valid;
  logic [ID_W-1:0]    rx_id;
  logic               rx_err;
  logic               busy;
  logic               cycle_done;
  logic [N_SLAVE-1:0] slave_ok;
  logic               overrun;
`ifdef POLL_RETRY_EN
  logic [7:0]         retry_cnt;

  modport master (
    input  pluse_us, fire_sync, tx_ack, tx_done, rx_valid, rx_id, rx_err,
    output tx_req, tx_id, tx_ctrl, busy, cycle_done, slave_ok, overrun,
           retry_cnt
  );

  modport slave (
    output pluse_us, fire_sync, tx_ack, tx_done, rx_valid, rx_id, rx_err,
    input  tx_req, tx_id, tx_ctrl, busy, cycle_done, slave_ok, overrun,
           retry_cnt
  );
`else
  modport master (
    input  pluse_us, fire_sync, tx_ack, tx_done, rx_valid, rx_id, rx_err,
    output tx_req, tx_id, tx_ctrl, busy, cycle_done, slave_ok, overrun
  );

  modport slave (
    output pluse_us, fire_sync, tx_ack, tx_done, rx_valid, rx_id, rx_err,
    input  tx_req, tx_id, tx_ctrl, busy, cycle_done, slave_ok, overrun
  );
`endif
endinterface

// File: rtl/poll_sch_m.sv
// ---------------------------------------------------------------------------
// poll_sch_m
//
// Purpose : master-side RS-485 poll scheduler (clk_sys domain). Each
//           fire_sync visits slaves BASE_ID .. BASE_ID+N_SLAVE-1 in order:
//           enable the driver, hand the ID to the TX framer (req/ack), wait
//           for the last bit, turn the line around, then wait a bounded time
//           (in pluse_us ticks) for the addressed reply. The per-slave
//           result bitmap is published with a one-cycle cycle_done.
//
// Ports   :
//   clk_sys  system clock
//   rst_n    synchronous active-low reset
//   bus      poll_sch_m_if.master (tick, fire, TX handshake, RX reply,
//            status: busy / cycle_done / slave_ok / overrun [/ retry_cnt])
//
// Optional feature macro: POLL_RETRY_EN
//   defined   : a slave's first failure (timeout or rx_err) is retried once
//               with the same index; retry_cnt counts retries (saturating,
//               cleared when a cycle starts).
//   undefined : no retry, the first failure advances to the next slave.
// ---------------------------------------------------------------------------
module poll_sch_m #(
  parameter int              N_SLAVE  = 8,
  parameter int              ID_W     = 6,
  parameter logic [ID_W-1:0] BASE_ID  = 6'h01,
  parameter int              GUARD_US = 10,
  parameter int              TO_US    = 200,
  parameter int              CNT_W    = 12
) (
  input  logic         clk_sys,
  input  logic         rst_n,
  poll_sch_m_if.master bus
);

  localparam int               IDX_W    = (N_SLAVE > 1) ? $clog2(N_SLAVE) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_SLAVE - 1);
  localparam logic [CNT_W-1:0] GUARD_C  = CNT_W'(GUARD_US);
  localparam logic [CNT_W-1:0] TO_C     = CNT_W'(TO_US);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRV_ON,
    S_REQ,
    S_SEND,
    S_DRV_OFF,
    S_WAIT_RX,
    S_NEXT,
    S_DONE
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   us_cnt;
  logic [CNT_W-1:0]   cnt_inc;
  logic [N_SLAVE-1:0] shadow;
  logic [N_SLAVE-1:0] slave_ok_r;
  logic [ID_W-1:0]    tx_id_r;
  logic               overrun_r;

  logic               cnt_en;
  logic               guard_hit;
  logic               to_hit;
  logic               rx_match;
  logic               idx_clr;
  logic               idx_inc;
  logic               shadow_set;
  logic               ok_load;

`ifdef POLL_RETRY_EN
  logic               retry_flag;
  logic               retry_set;
  logic               retry_clr;
  logic [7:0]         retry_cnt_r;
`endif

  // Saturating +1 on a us tick: the counter must never wrap, otherwise a
  // stuck timebase could make a long wait look short.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic             tick);
    if (tick && (v != {CNT_W{1'b1}})) begin
      return v + CNT_W'(1);
    end
    return v;
  endfunction

  // Guard and timeout compare against the count including the tick being
  // sampled now, so the exit happens on the edge of the Nth tick. With
  // GUARD_US = 0 the guard is met at once, giving exactly one clock.
  always_comb begin
    cnt_en    = (state == S_DRV_ON) || (state == S_DRV_OFF) || (state == S_WAIT_RX);
    cnt_inc   = sat_inc(us_cnt, bus.pluse_us);
    guard_hit = (cnt_inc >= GUARD_C);
    to_hit    = (cnt_inc >= TO_C);
    rx_match  = bus.rx_valid && !bus.rx_err && (bus.rx_id == tx_id_r);
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    idx_clr    = 1'b0;
    idx_inc    = 1'b0;
    shadow_set = 1'b0;
    ok_load    = 1'b0;
`ifdef POLL_RETRY_EN
    retry_set  = 1'b0;
    retry_clr  = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (bus.fire_sync) begin
          idx_clr   = 1'b1;
          state_nxt = S_DRV_ON;
        end
      end
      S_DRV_ON: begin
        if (guard_hit) begin
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        // A framer that finishes in the acceptance cycle skips SEND.
        if (bus.tx_ack) begin
          state_nxt = bus.tx_done ? S_DRV_OFF : S_SEND;
        end
      end
      S_SEND: begin
        if (bus.tx_done) begin
          state_nxt = S_DRV_OFF;
        end
      end
      S_DRV_OFF: begin
        if (guard_hit) begin
          state_nxt = S_WAIT_RX;
        end
      end
      S_WAIT_RX: begin
        // A matching reply wins over a timeout reached in the same cycle;
        // replies from other IDs are ignored and the wait continues.
        if (rx_match) begin
          shadow_set = 1'b1;
          state_nxt  = S_NEXT;
        end else if (bus.rx_err || to_hit) begin
`ifdef POLL_RETRY_EN
          if (!retry_flag) begin
            retry_set = 1'b1;
            state_nxt = S_DRV_ON;
          end else begin
            state_nxt = S_NEXT;
          end
`else
          state_nxt = S_NEXT;
`endif
        end
      end
      S_NEXT: begin
`ifdef POLL_RETRY_EN
        retry_clr = 1'b1;
`endif
        if (idx == IDX_LAST) begin
          ok_load   = 1'b1;
          state_nxt = S_DONE;
        end else begin
          idx_inc   = 1'b1;
          state_nxt = S_DRV_ON;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      idx        <= '0;
      us_cnt     <= '0;
      shadow     <= '0;
      slave_ok_r <= '0;
      tx_id_r    <= '0;
      overrun_r  <= 1'b0;
    end else begin
      overrun_r <= bus.fire_sync && (state != S_IDLE);

      // Counter restarts on every state change, so each timed state
      // (DRV_ON, DRV_OFF, WAIT_RX) starts from zero.
      if (state_nxt != state) begin
        us_cnt <= '0;
      end else if (cnt_en) begin
        us_cnt <= cnt_inc;
      end

      if (idx_clr) begin
        idx     <= '0;
        shadow  <= '0;
        tx_id_r <= BASE_ID;
      end else if (idx_inc) begin
        idx     <= idx + IDX_W'(1);
        tx_id_r <= tx_id_r + ID_W'(1);
      end

      if (shadow_set) begin
        shadow[idx] <= 1'b1;
      end

      // Loaded on the NEXT->DONE edge so slave_ok changes together with
      // the cycle_done pulse.
      if (ok_load) begin
        slave_ok_r <= shadow;
      end
    end
  end

`ifdef POLL_RETRY_EN
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      retry_flag  <= 1'b0;
      retry_cnt_r <= '0;
    end else begin
      if (retry_clr || idx_clr) begin
        retry_flag <= 1'b0;
      end else if (retry_set) begin
        retry_flag <= 1'b1;
      end

      if (idx_clr) begin
        retry_cnt_r <= '0;
      end else if (retry_set && (retry_cnt_r != 8'hFF)) begin
        retry_cnt_r <= retry_cnt_r + 8'd1;
      end
    end
  end

  assign bus.retry_cnt = retry_cnt_r;
`endif

  // Driver enable only while the master owns the line.
  assign bus.tx_ctrl    = (state == S_DRV_ON) || (state == S_REQ) || (state == S_SEND);
  assign bus.tx_req     = (state == S_REQ);
  assign bus.tx_id      = tx_id_r;
  assign bus.busy       = (state != S_IDLE);
  assign bus.cycle_done = (state == S_DONE);
  assign bus.slave_ok   = slave_ok_r;
  assign bus.overrun    = overrun_r;

endmodule
